// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - round-robin time-sharing controller for one shared W-bit adder
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W = 64,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_A,
    input  logic [NREQ*W-1:0] req_B,
    input  logic [NREQ-1:0]   req_sub,
    output logic [W-1:0]      add_A,
    output logic [W-1:0]      add_B,
    output logic              add_Cin,
    input  logic [W-1:0]      add_S,
    input  logic              add_Cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_S,
    output logic              res_Cout,
    output logic              res_V,
    output logic [IDW-1:0]    res_id
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDW-1:0] last_gnt;
    logic           grant_any;
    logic [IDW-1:0] grant_idx;
    logic           accept;

    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_sub;

    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           op_cin;
    logic [IDW-1:0] op_id;

    logic [W-1:0]   r_s;
    logic           r_cout;
    logic           r_v;
    logic [IDW-1:0] r_id;
    logic           overflow;

    // Requester index k places after base, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
        return IDW'((int'(base) + k) % NREQ);
    endfunction

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_any && req_valid[rr_index(last_gnt, k)]) begin
                grant_any = 1'b1;
                grant_idx = rr_index(last_gnt, k);
            end
        end
    end

    // Only the winner sees ready, and only while the adder is free.
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign accept = (state == ST_IDLE) && grant_any;

    // Pick the winner's operands out of the flattened request buses.
    always_comb begin
        sel_a   = req_A[int'(grant_idx)*W +: W];
        sel_b   = req_B[int'(grant_idx)*W +: W];
        sel_sub = req_sub[grant_idx];
    end

    // Next-state logic: one cycle of adder use, then hold the result until taken.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (grant_any) state_nx = ST_EXEC;
            ST_EXEC: state_nx = ST_DONE;
            ST_DONE: if (res_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant pointer moves only when a grant is actually taken; reset makes requester 0 first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt <= IDW'(NREQ - 1);
        end else if (accept) begin
            last_gnt <= grant_idx;
        end
    end

    // Operand registers: subtraction is A + ~B + 1, so B is inverted and carry-in forced here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            op_id  <= '0;
        end else if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_sub ? ~sel_b : sel_b;
            op_cin <= sel_sub;
            op_id  <= grant_idx;
        end
    end

    assign add_A   = op_a;
    assign add_B   = op_b;
    assign add_Cin = op_cin;

    // Signed overflow from the operands as the adder sees them (B already inverted for subtract).
    assign overflow = (op_a[W-1] == op_b[W-1]) && (add_S[W-1] != op_a[W-1]);

    // Result registers sample the adder only during EXEC and are otherwise frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_v    <= 1'b0;
            r_id   <= '0;
        end else if (state == ST_EXEC) begin
            r_s    <= add_S;
            r_cout <= add_Cout;
            r_v    <= overflow;
            r_id   <= op_id;
        end
    end

    assign res_valid = (state == ST_DONE);
    assign res_S     = r_s;
    assign res_Cout  = r_cout;
    assign res_V     = r_v;
    assign res_id    = r_id;

endmodule
